truth_table_checker: RTL and testbench

- Synthesizable stimulus/response engine; the hardware counterpart of a stimulus bench for small combinational exercise blocks.
- On each run it:
  - walks every input combination of a 4-in/2-out combinational DUT (A,B,C,D -> E,F);
  - waits a settle time per vector;
  - samples the DUT outputs and compares them against a parameterized expected truth table.
- Reports the mismatch count, the first failing vector and an overall pass flag.
- Sits beside the DUT on the lab board; the DUT connects point-to-point to dut_in/dut_out.

---
 rtl/truth_table_pkg.sv | 46 ++++
 rtl/settle_timer.sv | 43 ++++
 rtl/truth_table_checker.sv | 143 ++++++++++++++
 tb/tb_truth_table_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_pkg
// Description : Shared types and helpers for the truth-table checker.
//               - state_t   : checker FSM states
//               - N_VEC     : vector count of the default 4-input DUT
//               - exp_slice : extracts one vector's expected outputs from a
//                             packed expected-value table
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned N_IN_DEFAULT = 4;
  localparam int unsigned N_VEC        = 2 ** N_IN_DEFAULT;

  // Widest table / output slice exp_slice can serve. Callers zero-extend
  // their table to MAX_TABLE_W and compare against all MAX_OUT_W bits.
  localparam int unsigned MAX_TABLE_W = 4096;
  localparam int unsigned MAX_OUT_W   = 16;

  // Expected outputs for vector vec: tbl[vec*n_out +: n_out], with every bit
  // at or above n_out returned as zero.
  function automatic logic [MAX_OUT_W-1:0] exp_slice(
    input logic [MAX_TABLE_W-1:0] tbl,
    input int unsigned            vec,
    input int unsigned            n_out
  );
    logic [MAX_OUT_W-1:0] res;
    res = '0;
    for (int unsigned b = 0; b < MAX_OUT_W; b++) begin
      if (b < n_out) begin
        res[b] = tbl[vec * n_out + b];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : settle_timer
// Description : Loadable down-counter that times how long a vector is held
//               on the DUT before its response is sampled.
// Ports       : clk     - system clock, rising edge
//               rst_n   - asynchronous active-low reset
//               load    - reload the counter with SETTLE-1
//               en      - count down by one (stops at zero)
//               expired - counter is at zero
// Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int                 c_cnt_w    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(SETTLE - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Loaded with SETTLE-1 on entry to DRIVE, so expired asserts in the
  // SETTLE-th DRIVE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_checker
// Description : Stimulus/response engine for a small combinational DUT.
//               Each run walks all 2**N_IN input vectors, holds each for
//               SETTLE cycles, samples the DUT response and compares it with
//               EXP_TABLE. Reports mismatch count, first failing vector and a
//               pass flag.
// Ports       : clk              - system clock, rising edge
//               rst_n            - asynchronous active-low reset
//               start            - run request (honoured in IDLE and DONE)
//               dut_in           - DUT drive, MSB = A ... LSB = D
//               dut_out          - DUT response, MSB = E, LSB = F
//               busy             - run in progress (DRIVE or SAMPLE)
//               done             - run finished, results stable
//               pass             - no mismatches (valid while done)
//               err_count        - mismatching vectors this run
//               first_fail_valid - a mismatch has been seen this run
//               first_fail_vec   - index of the first mismatching vector
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int                           N_IN      = 4,
  parameter int                           N_OUT     = 2,
  parameter int                           SETTLE    = 2,
  parameter logic [N_OUT*(2**N_IN)-1:0]   EXP_TABLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);

  localparam logic [MAX_TABLE_W-1:0] c_exp_ext  = MAX_TABLE_W'(EXP_TABLE);
  localparam logic [N_IN-1:0]        c_last_vec = '1;
  localparam logic [N_IN:0]          c_err_max  = {1'b1, {N_IN{1'b0}}};

  state_t               r_state;
  state_t               w_state_next;
  logic [N_IN-1:0]      r_vec;
  logic [N_IN:0]        r_err_count;
  logic                 r_ff_valid;
  logic [N_IN-1:0]      r_ff_vec;
  logic                 r_pass;

  logic                 w_start_run;
  logic                 w_expired;
  logic                 w_mismatch;
  logic [MAX_OUT_W-1:0] w_exp;
  logic [MAX_OUT_W-1:0] w_resp;

  // A run starts only from the idle-like states; start during a run is
  // deliberately ignored.
  assign w_start_run = start && ((r_state == IDLE) || (r_state == DONE));

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_start_run || (r_state == SAMPLE)),
    .en      (r_state == DRIVE),
    .expired (w_expired)
  );

  // Case-inequality so an undriven or X response counts as a mismatch in
  // simulation; synthesis treats it as an ordinary compare.
  assign w_exp      = exp_slice(c_exp_ext, int'(r_vec), N_OUT);
  assign w_resp     = {{(MAX_OUT_W-N_OUT){1'b0}}, dut_out};
  assign w_mismatch = (w_resp !== w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = DRIVE;
      DRIVE:   if (w_expired) w_state_next = SAMPLE;
      SAMPLE:  w_state_next = (r_vec == c_last_vec) ? DONE : DRIVE;
      DONE:    if (start) w_state_next = DRIVE;
      default: w_state_next = IDLE;
    endcase
  end

  // Vector counter and result registers. r_vec wraps to zero after the last
  // vector, which is also what dut_in shows while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec       <= '0;
      r_err_count <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_vec    <= '0;
      r_pass      <= 1'b0;
    end else if (w_start_run) begin
      r_vec       <= '0;
      r_err_count <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_vec    <= '0;
      r_pass      <= 1'b0;
    end else if (r_state == SAMPLE) begin
      r_vec <= r_vec + N_IN'(1);
      if (w_mismatch) begin
        if (r_err_count != c_err_max) begin
          r_err_count <= r_err_count + (N_IN+1)'(1);
        end
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_vec   <= r_vec;
        end
      end
      // Fold the last vector's result in directly so pass is already
      // correct in the first DONE cycle.
      if (r_vec == c_last_vec) begin
        r_pass <= !w_mismatch && (r_err_count == '0);
      end
    end
  end

  assign dut_in           = r_vec;
  assign busy             = (r_state == DRIVE) || (r_state == SAMPLE);
  assign done             = (r_state == DONE);
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_checker
// Description : Self-checking bench for truth_table_checker. Two instances:
//               dut_a (SETTLE=2, table from E=A&B|C, F=B^D, optional fault on
//               vector 7) and dut_b (SETTLE=1, all-zero table, response 2'b11).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

  function automatic logic [1:0] golden(input logic [3:0] v);
    logic e, f;
    e = (v[3] & v[2]) | v[1];
    f = v[2] ^ v[0];
    return {e, f};
  endfunction

  function automatic logic [31:0] build_table();
    logic [31:0] t;
    t = '0;
    for (int v = 0; v < 16; v++) t[v*2 +: 2] = golden(4'(v));
    return t;
  endfunction

  localparam logic [31:0] TBL_A = build_table();

  // Lab DUT for instance a: golden model, E forced low on 4'b0111 when faulted
  function automatic logic [1:0] lab_a(input logic [3:0] v, input logic flt);
    logic [1:0] o;
    o = golden(v);
    if (flt && (v == 4'd7)) o[1] = 1'b0;
    return o;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       fault;
  logic       running;
  int         edge_cnt = 0;
  int         n_err = 0;
  int         n_checks = 0;

  logic [3:0] dut_in_a, dut_in_b, ffvec_a, ffvec_b;
  logic [1:0] dut_out_a, dut_out_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
  logic [4:0] err_a, err_b;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assign dut_out_a = lab_a(dut_in_a, fault);
  assign dut_out_b = 2'b11;

  truth_table_checker #(
    .N_IN(4), .N_OUT(2), .SETTLE(2), .EXP_TABLE(TBL_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  truth_table_checker #(
    .N_IN(4), .N_OUT(2), .SETTLE(1), .EXP_TABLE(32'd0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 = idle, 1 = running (j = cycles since accepted start), 2 = done
  int          m_mode [2];
  int          m_j    [2];
  logic [15:0] m_fail [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] fail_mask(input int i, input logic flt);
    logic [15:0] m;
    logic [31:0] t;
    logic [1:0]  got, want;
    m = '0;
    t = (i == 0) ? TBL_A : 32'd0;
    for (int v = 0; v < 16; v++) begin
      got  = (i == 0) ? lab_a(4'(v), flt) : 2'b11;
      want = t[v*2 +: 2];
      if (got !== want) m[v] = 1'b1;
    end
    return m;
  endfunction

  function automatic int cnt_below(input logic [15:0] m, input int n);
    int c;
    c = 0;
    for (int v = 0; v < n; v++) if (m[v]) c++;
    return c;
  endfunction

  function automatic int first_below(input logic [15:0] m, input int n);
    for (int v = 0; v < n; v++) if (m[v]) return v;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0;
        m_j[i]    <= 0;
        m_fail[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] != 1) begin
          if ((i == 0) ? start_a : start_b) begin
            m_mode[i] <= 1;
            m_j[i]    <= 0;
            m_fail[i] <= fail_mask(i, fault);
          end
        end else begin
          m_j[i] <= m_j[i] + 1;
          if (m_j[i] + 1 == 16 * (settle_of(i) + 1)) m_mode[i] <= 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_one(input int i);
    logic [31:0] a_din, a_busy, a_done, a_pass, a_err, a_ffv, a_ffvec;
    logic [31:0] e_din, e_busy, e_done, e_pass, e_err, e_ffv, e_ffvec;
    string       p;
    int          cur;
    p       = (i == 0) ? "a" : "b";
    a_din   = (i == 0) ? 32'(dut_in_a) : 32'(dut_in_b);
    a_busy  = (i == 0) ? 32'(busy_a)   : 32'(busy_b);
    a_done  = (i == 0) ? 32'(done_a)   : 32'(done_b);
    a_pass  = (i == 0) ? 32'(pass_a)   : 32'(pass_b);
    a_err   = (i == 0) ? 32'(err_a)    : 32'(err_b);
    a_ffv   = (i == 0) ? 32'(ffv_a)    : 32'(ffv_b);
    a_ffvec = (i == 0) ? 32'(ffvec_a)  : 32'(ffvec_b);
    e_din = 0; e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_ffv = 0; e_ffvec = 0;
    if (rst_n && m_mode[i] == 1) begin
      cur     = m_j[i] / (settle_of(i) + 1);
      e_busy  = 1;
      e_din   = 32'(cur);
      e_err   = 32'(cnt_below(m_fail[i], cur));
      e_ffv   = (e_err != 0) ? 1 : 0;
      e_ffvec = 32'(first_below(m_fail[i], cur));
    end else if (rst_n && m_mode[i] == 2) begin
      e_done  = 1;
      e_err   = 32'(cnt_below(m_fail[i], 16));
      e_pass  = (e_err == 0) ? 1 : 0;
      e_ffv   = (e_err != 0) ? 1 : 0;
      e_ffvec = 32'(first_below(m_fail[i], 16));
    end
    chk({p, ".dut_in"}, a_din, e_din);
    chk({p, ".busy"}, a_busy, e_busy);
    chk({p, ".done"}, a_done, e_done);
    chk({p, ".pass"}, a_pass, e_pass);
    chk({p, ".err_count"}, a_err, e_err);
    chk({p, ".first_fail_valid"}, a_ffv, e_ffv);
    chk({p, ".first_fail_vec"}, a_ffvec, e_ffvec);
  endtask

  always @(negedge clk) begin
    if (running) begin
      check_one(0);
      check_one(1);
    end
  end

  // ---------------- directed sequence ----------------
  // Called at a negedge: start is high across exactly one rising edge (t0).
  task automatic pulse(input int i, output int t0);
    if (i == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    t0 = edge_cnt;
    if (i == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  task automatic wait_done(input int i, output int de);
    de = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((i == 0) ? done_a : done_b) begin
        de = edge_cnt;
        return;
      end
    end
    chk("wait_done_timeout", 32'(0), 32'(1));
  endtask

  int t0, de;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; fault = 1'b0; running = 1'b1;
    #12 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset.done_a", 32'(done_a), 0);
    chk("reset.err_a", 32'(err_a), 0);

    // Scenario 1: clean run, start sampled at edge 10
    while (edge_cnt != 9) @(negedge clk);
    pulse(0, t0);
    chk("s1.start_edge", 32'(t0), 10);
    wait_done(0, de);
    chk("s1.done_edge", 32'(de), 58);
    chk("s1.pass", 32'(pass_a), 1);
    chk("s1.err_count", 32'(err_a), 0);
    chk("s1.first_fail_valid", 32'(ffv_a), 0);

    // Scenario 3: start while busy is ignored
    @(negedge clk);
    pulse(0, t0);
    repeat (11) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, de);
    chk("s3.latency", 32'(de - t0), 48);
    chk("s3.pass", 32'(pass_a), 1);
    chk("s3.err_count", 32'(err_a), 0);

    // Scenario 4: reset mid-run
    @(negedge clk);
    pulse(0, t0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s4.rst.dut_in", 32'(dut_in_a), 0);
    chk("s4.rst.busy", 32'(busy_a), 0);
    chk("s4.rst.done", 32'(done_a), 0);
    chk("s4.rst.pass", 32'(pass_a), 0);
    chk("s4.rst.err_count", 32'(err_a), 0);
    chk("s4.rst.first_fail_valid", 32'(ffv_a), 0);
    chk("s4.rst.first_fail_vec", 32'(ffvec_a), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("s4.idle.busy", 32'(busy_a), 0);
    pulse(0, t0);
    wait_done(0, de);
    chk("s4.latency", 32'(de - t0), 48);
    chk("s4.pass", 32'(pass_a), 1);

    // Scenario 2 + 5: single fault on vector 7, then restart from DONE clean
    @(negedge clk);
    fault = 1'b1;
    pulse(0, t0);
    wait_done(0, de);
    chk("s2.err_count", 32'(err_a), 1);
    chk("s2.first_fail_vec", 32'(ffvec_a), 7);
    chk("s2.first_fail_valid", 32'(ffv_a), 1);
    chk("s2.pass", 32'(pass_a), 0);
    fault = 1'b0;
    pulse(0, t0);
    chk("s5.done_drop", 32'(done_a), 0);
    chk("s5.err_cleared", 32'(err_a), 0);
    chk("s5.ffv_cleared", 32'(ffv_a), 0);
    wait_done(0, de);
    chk("s5.latency", 32'(de - t0), 48);
    chk("s5.pass", 32'(pass_a), 1);

    // Scenario 6: all vectors fail, SETTLE=1
    @(negedge clk);
    pulse(1, t0);
    wait_done(1, de);
    chk("s6.latency", 32'(de - t0), 32);
    chk("s6.err_count", 32'(err_b), 16);
    chk("s6.first_fail_vec", 32'(ffvec_b), 0);
    chk("s6.pass", 32'(pass_b), 0);

    repeat (2) @(negedge clk);
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
